// File: rtl/byte_bus_to_pc_bus_pkg.sv
// Shared definitions for the byte-bus to pc_bus upsizing bridge: FSM encoding,
// line geometry helpers and the byte-lane enable decode.
package byte_bus_to_pc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_FILL = 2'd3
  } bridge_state_e;

  localparam int unsigned DEF_BURST  = 4;
  localparam int unsigned LINE_BYTES = 4 * DEF_BURST;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

  function automatic int unsigned line_off_w(input int unsigned burst);
    return $clog2(4 * burst);
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/byte_line_buffer.sv
// One-line prefetch buffer: BURST x 32b words with tag/valid, a word fill port,
// a byte write-through port and a combinational byte read select.
module byte_line_buffer
  import byte_bus_to_pc_bus_pkg::*;
#(
  parameter int unsigned BURST = 4,
  parameter int unsigned OFF_W = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              invalidate,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [31:0]       fill_word,
  input  logic              fill_last,
  input  logic [31-OFF_W:0] fill_tag,
  input  logic [31-OFF_W:0] lookup_tag,
  input  logic [OFF_W-1:0]  lookup_off,
  input  logic              wt_en,
  input  logic [7:0]        wt_byte,
  output logic              hit,
  output logic [7:0]        rd_byte
);

  logic [BURST-1:0][31:0] words;
  logic [31-OFF_W:0]      tag_q;
  logic                   line_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic [4:0]             sel_bit;

  assign sel_idx = IDX_W'(lookup_off >> 2);
  assign sel_bit = {lookup_off[1:0], 3'b000};
  assign hit     = line_valid && (tag_q == lookup_tag);
  assign rd_byte = words[sel_idx][sel_bit +: 8];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      line_valid <= 1'b0;
      tag_q      <= '0;
      words      <= '0;
    end else begin
      if (invalidate) line_valid <= 1'b0;
      if (fill_en) begin
        words[fill_idx] <= fill_word;
        if (fill_last) begin
          tag_q      <= fill_tag;
          line_valid <= 1'b1;
        end
      end
      // Keep the buffered copy coherent with posted byte writes.
      if (wt_en && hit) words[sel_idx][sel_bit +: 8] <= wt_byte;
    end
  end

endmodule

// File: rtl/byte_bus_to_pc_bus.sv
// 8-bit Avalon-MM slave to 32-bit bursting pc_bus master: posted byte writes,
// reads served from a one-line buffer refilled by one aligned burst per miss.
module byte_bus_to_pc_bus
  import byte_bus_to_pc_bus_pkg::*;
#(
  parameter int unsigned AW        = 17,
  parameter logic [31:0] BASE_ADDR = 32'h000A0000,
  parameter int unsigned BURST     = 4
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [AW-1:0] byte_address,
  input  logic          byte_read,
  input  logic          byte_write,
  input  logic [7:0]    byte_writedata,
  output logic          byte_waitrequest,
  output logic [7:0]    byte_readdata,
  output logic          byte_readdatavalid,
  output logic [31:0]   pc_bus_address,
  output logic [3:0]    pc_bus_byteenable,
  output logic          pc_bus_read,
  output logic          pc_bus_write,
  output logic [31:0]   pc_bus_writedata,
  output logic [2:0]    pc_bus_burstcount,
  input  logic          pc_bus_waitrequest,
  input  logic [31:0]   pc_bus_readdata,
  input  logic          pc_bus_readdatavalid
);

  localparam int unsigned L_OFF_W   = line_off_w(BURST);
  localparam int unsigned IDX_W     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST - 1);

  bridge_state_e    state_q, state_d;
  logic [31:0]      pc_addr;
  logic [31:0]      cmd_addr;
  logic [3:0]       cmd_be;
  logic [31:0]      cmd_data;
  logic [IDX_W-1:0] beat_q;
  logic             hit;
  logic [7:0]       sel_byte;
  logic             accept_wr, accept_rd, miss, grant, fill_en, fill_last;

  assign pc_addr = BASE_ADDR + 32'(byte_address);

  byte_line_buffer #(
    .BURST (BURST),
    .OFF_W (L_OFF_W),
    .IDX_W (IDX_W)
  ) u_line (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .invalidate (miss),
    .fill_en    (fill_en),
    .fill_idx   (beat_q),
    .fill_word  (pc_bus_readdata),
    .fill_last  (fill_last),
    .fill_tag   (cmd_addr[31:L_OFF_W]),
    .lookup_tag (pc_addr[31:L_OFF_W]),
    .lookup_off (pc_addr[L_OFF_W-1:0]),
    .wt_en      (accept_wr),
    .wt_byte    (byte_writedata),
    .hit        (hit),
    .rd_byte    (sel_byte)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Write wins over read if both are ever presented together.
  always_comb begin
    state_d   = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    miss      = 1'b0;
    grant     = 1'b0;
    fill_en   = 1'b0;
    fill_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_write) begin
          accept_wr = 1'b1;
          state_d   = ST_WR_REQ;
        end else if (byte_read) begin
          if (hit) begin
            accept_rd = 1'b1;
          end else begin
            miss    = 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: if (!pc_bus_waitrequest) state_d = ST_IDLE;
      ST_RD_REQ: begin
        if (!pc_bus_waitrequest) begin
          grant   = 1'b1;
          state_d = ST_RD_FILL;
        end
      end
      ST_RD_FILL: begin
        if (pc_bus_readdatavalid) begin
          fill_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            fill_last = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cmd_addr           <= '0;
      cmd_be             <= '0;
      cmd_data           <= '0;
      beat_q             <= '0;
      byte_readdata      <= '0;
      byte_readdatavalid <= 1'b0;
    end else begin
      if (accept_wr) begin
        cmd_addr <= {pc_addr[31:2], 2'b00};
        cmd_be   <= lane_enable(pc_addr[1:0]);
        cmd_data <= {4{byte_writedata}};
      end else if (miss) begin
        cmd_addr <= {pc_addr[31:L_OFF_W], {L_OFF_W{1'b0}}};
      end
      if (grant)        beat_q <= '0;
      else if (fill_en) beat_q <= beat_q + IDX_W'(1);
      byte_readdatavalid <= accept_rd;
      if (accept_rd) byte_readdata <= sel_byte;
    end
  end

  assign byte_waitrequest  = (state_q != ST_IDLE) || (byte_read && !hit);
  assign pc_bus_write      = (state_q == ST_WR_REQ);
  assign pc_bus_read       = (state_q == ST_RD_REQ);
  assign pc_bus_address    = cmd_addr;
  assign pc_bus_writedata  = cmd_data;
  assign pc_bus_byteenable = pc_bus_write ? cmd_be : (pc_bus_read ? 4'hF : 4'h0);
  assign pc_bus_burstcount = pc_bus_read ? 3'(BURST) : 3'd1;

endmodule

// File: tb/tb_byte_bus_to_pc_bus.sv
// Scoreboard bench for byte_bus_to_pc_bus: byte-array reference model, pc_bus slave
// memory with programmable stalls and beat gaps.
module tb_byte_bus_to_pc_bus;

  localparam int unsigned AW    = 17;
  localparam logic [31:0] BASE  = 32'h000A0000;
  localparam int unsigned BURST = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_exp_t;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] byte_address = '0;
  logic          byte_read = 1'b0;
  logic          byte_write = 1'b0;
  logic [7:0]    byte_writedata = '0;
  logic          byte_waitrequest;
  logic [7:0]    byte_readdata;
  logic          byte_readdatavalid;
  logic [31:0]   pc_bus_address;
  logic [3:0]    pc_bus_byteenable;
  logic          pc_bus_read;
  logic          pc_bus_write;
  logic [31:0]   pc_bus_writedata;
  logic [2:0]    pc_bus_burstcount;
  logic          pc_bus_waitrequest = 1'b0;
  logic [31:0]   pc_bus_readdata = '0;
  logic          pc_bus_readdatavalid = 1'b0;

  always #5 clk_sys = ~clk_sys;

  byte_bus_to_pc_bus #(.AW(AW), .BASE_ADDR(BASE), .BURST(BURST)) dut (
    .clk_sys              (clk_sys),
    .rst                  (rst),
    .byte_address         (byte_address),
    .byte_read            (byte_read),
    .byte_write           (byte_write),
    .byte_writedata       (byte_writedata),
    .byte_waitrequest     (byte_waitrequest),
    .byte_readdata        (byte_readdata),
    .byte_readdatavalid   (byte_readdatavalid),
    .pc_bus_address       (pc_bus_address),
    .pc_bus_byteenable    (pc_bus_byteenable),
    .pc_bus_read          (pc_bus_read),
    .pc_bus_write         (pc_bus_write),
    .pc_bus_writedata     (pc_bus_writedata),
    .pc_bus_burstcount    (pc_bus_burstcount),
    .pc_bus_waitrequest   (pc_bus_waitrequest),
    .pc_bus_readdata      (pc_bus_readdata),
    .pc_bus_readdatavalid (pc_bus_readdatavalid)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  logic [7:0]  ref_mem [256];
  logic [7:0]  slv_mem [256];
  logic [7:0]  exp_rd[$];
  wr_exp_t     exp_wr[$];
  int unsigned beat_q[$];

  logic        stall_rand = 1'b0;
  logic        gap_rand = 1'b0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  int          rd_cmds = 0;
  int          wr_cmds = 0;
  int          beats_given = 0;
  int          cyc = 0;
  logic [31:0] last_rd_addr = '0;
  logic [3:0]  last_wr_be = '0;
  logic        held = 1'b0;
  logic [40:0] held_ctl = '0;
  logic [31:0] held_wd = '0;

  always @(posedge clk_sys) cyc++;

  always @(posedge clk_sys)
    if (!rst) assert (!(byte_read && byte_write)) else $error("byte_read and byte_write together");

  // pc_bus slave: decisions at negedge take effect at the following posedge.
  always @(negedge clk_sys) begin
    logic        cmd;
    int unsigned a;
    wr_exp_t     e;
    cmd = pc_bus_read || pc_bus_write;
    if (held && !rst) begin
      chk("hold_ctl", 64'({pc_bus_read, pc_bus_write, pc_bus_byteenable, pc_bus_burstcount, pc_bus_address}), 64'(held_ctl));
      chk("hold_wdata", 64'(pc_bus_writedata), 64'(held_wd));
    end
    pc_bus_readdatavalid = 1'b0;
    if (beat_q.size() > 0 && (!gap_rand || $urandom_range(0, 2) != 0)) begin
      a = (beat_q.pop_front() - BASE) & 32'hFC;
      pc_bus_readdata = {slv_mem[a+3], slv_mem[a+2], slv_mem[a+1], slv_mem[a]};
      pc_bus_readdatavalid = 1'b1;
      beats_given++;
    end
    pc_bus_waitrequest = 1'b0;
    if (cmd) begin
      if (stall_cnt > 0) begin
        pc_bus_waitrequest = 1'b1;
        stall_cnt--;
      end else if (stall_rand) begin
        pc_bus_waitrequest = ($urandom_range(0, 2) == 0);
      end
    end
    if (cmd && pc_bus_waitrequest) stall_seen++;
    held     = cmd && pc_bus_waitrequest;
    held_ctl = {pc_bus_read, pc_bus_write, pc_bus_byteenable, pc_bus_burstcount, pc_bus_address};
    held_wd  = pc_bus_writedata;
    if (cmd && !pc_bus_waitrequest) begin
      if (pc_bus_read) begin
        rd_cmds++;
        last_rd_addr = pc_bus_address;
        chk("rd_burst", 64'(pc_bus_burstcount), 64'(BURST));
        chk("rd_be", 64'(pc_bus_byteenable), 64'hF);
        chk("rd_align", 64'(pc_bus_address[3:0]), 64'h0);
        for (int i = 0; i < int'(BURST); i++) beat_q.push_back(pc_bus_address + 32'(4 * i));
      end else begin
        wr_cmds++;
        last_wr_be = pc_bus_byteenable;
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(pc_bus_address), 64'(e.addr));
          chk("wr_be", 64'(pc_bus_byteenable), 64'(e.be));
          chk("wr_data", 64'(pc_bus_writedata), 64'(e.data));
          chk("wr_burst", 64'(pc_bus_burstcount), 64'd1);
        end
        for (int l = 0; l < 4; l++)
          if (pc_bus_byteenable[l])
            slv_mem[(pc_bus_address - BASE + 32'(l)) & 32'hFF] = pc_bus_writedata[8*l +: 8];
      end
    end
  end

  always @(negedge clk_sys) begin
    if (byte_readdatavalid) begin
      if (exp_rd.size() == 0) chk("rdv_unexpected", 64'd1, 64'd0);
      else chk("rdata", 64'(byte_readdata), 64'(exp_rd.pop_front()));
    end
  end

  task automatic do_read(input int a);
    int n;
    byte_read = 1'b1;
    byte_write = 1'b0;
    byte_address = AW'(a);
    n = 0;
    forever begin
      @(negedge clk_sys);
      if (!byte_waitrequest) break;
      n++;
      if (n > 300) begin
        chk("rd_timeout", 64'd1, 64'd0);
        break;
      end
    end
    if (!byte_waitrequest) exp_rd.push_back(ref_mem[a & 255]);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    int n;
    wr_exp_t e;
    byte_write = 1'b1;
    byte_read = 1'b0;
    byte_address = AW'(a);
    byte_writedata = d;
    n = 0;
    forever begin
      @(negedge clk_sys);
      if (!byte_waitrequest) break;
      n++;
      if (n > 300) begin
        chk("wr_timeout", 64'd1, 64'd0);
        break;
      end
    end
    if (!byte_waitrequest) begin
      ref_mem[a & 255] = d;
      e.addr = (BASE + 32'(a)) & 32'hFFFF_FFFC;
      e.be   = 4'b0001 << (a & 3);
      e.data = {4{d}};
      exp_wr.push_back(e);
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_idle(input int n);
    byte_read = 1'b0;
    byte_write = 1'b0;
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_read"}, 64'(pc_bus_read), 64'd0);
    chk({tag, "_pc_write"}, 64'(pc_bus_write), 64'd0);
    chk({tag, "_pc_be"}, 64'(pc_bus_byteenable), 64'd0);
    chk({tag, "_pc_burst"}, 64'(pc_bus_burstcount), 64'd1);
    chk({tag, "_pc_addr"}, 64'(pc_bus_address), 64'd0);
    chk({tag, "_pc_wdata"}, 64'(pc_bus_writedata), 64'd0);
    chk({tag, "_rdv"}, 64'(byte_readdatavalid), 64'd0);
    chk({tag, "_rdata"}, 64'(byte_readdata), 64'd0);
  endtask

  initial begin
    int w0, r0, s0, c0, b1, n;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = (i < 'h40) ? 8'(i & 'hF) : 8'($urandom_range(0, 255));
      ref_mem[i] = slv_mem[i];
    end

    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_reset_outputs("reset");
    @(posedge clk_sys);
    #1 rst = 1'b0;

    // 1: posted byte write with three pc_bus stall cycles
    w0 = wr_cmds; s0 = stall_seen; stall_cnt = 3;
    do_write('h3, 8'h5A);
    bus_idle(8);
    chk("t1_wr_cnt", 64'(wr_cmds - w0), 64'd1);
    chk("t1_stalls", 64'(stall_seen - s0), 64'd3);
    chk("t1_be", 64'(last_wr_be), 64'b1000);

    // 2: cold miss then 15 back-to-back hits
    r0 = rd_cmds; w0 = wr_cmds;
    do_read('h10);
    c0 = cyc;
    for (int a = 'h11; a <= 'h1F; a++) do_read(a);
    chk("t2_hit_cycles", 64'(cyc - c0), 64'd15);
    bus_idle(3);
    chk("t2_rd_cmds", 64'(rd_cmds - r0), 64'd1);
    chk("t2_wr_cmds", 64'(wr_cmds - w0), 64'd0);
    chk("t2_rd_addr", 64'(last_rd_addr), 64'h000A0010);

    // 3: write-through into the valid line
    r0 = rd_cmds; w0 = wr_cmds;
    do_write('h15, 8'hAA);
    do_read('h15);
    bus_idle(8);
    chk("t3_rd_cmds", 64'(rd_cmds - r0), 64'd0);
    chk("t3_wr_cmds", 64'(wr_cmds - w0), 64'd1);
    chk("t3_be", 64'(last_wr_be), 64'b0010);

    // 4: miss on another line evicts the old one
    r0 = rd_cmds;
    do_read('h20);
    bus_idle(3);
    chk("t4_rd_cmds", 64'(rd_cmds - r0), 64'd1);
    chk("t4_rd_addr", 64'(last_rd_addr), 64'h000A0020);
    do_read('h10);
    do_read('h15);
    bus_idle(3);
    chk("t4_refetch", 64'(rd_cmds - r0), 64'd2);
    chk("t4_rd_addr2", 64'(last_rd_addr), 64'h000A0010);

    // 5: reset after two of four beats
    r0 = rd_cmds; b1 = beats_given;
    byte_read = 1'b1; byte_address = AW'('h30);
    n = 0;
    while (beats_given - b1 < 2 && n < 100) begin
      @(posedge clk_sys);
      #1 n++;
    end
    chk("t5_two_beats", 64'(beats_given - b1), 64'd2);
    rst = 1'b1; byte_read = 1'b0;
    @(posedge clk_sys);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    chk_reset_outputs("t5");
    chk("t5_waitreq", 64'(byte_waitrequest), 64'd0);
    n = 0;
    while (beat_q.size() > 0 && n < 100) begin
      @(posedge clk_sys);
      #1 n++;
    end
    chk("t5_drained", 64'(beat_q.size()), 64'd0);
    bus_idle(3);
    b1 = beats_given;
    do_read('h30);
    do_read('h33);
    bus_idle(3);
    chk("t5_rd_cmds", 64'(rd_cmds - r0), 64'd2);
    chk("t5_full_burst", 64'(beats_given - b1), 64'(BURST));

    // 6: random mix with random stalls and beat gaps
    stall_rand = 1'b1; gap_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int a;
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 6) do_read(a);
      else do_write(a, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) bus_idle(1);
    end
    bus_idle(2);
    n = 0;
    while ((exp_rd.size() > 0 || exp_wr.size() > 0) && n < 200) begin
      @(posedge clk_sys);
      #1 n++;
    end
    chk("sb_rd_empty", 64'(exp_rd.size()), 64'd0);
    chk("sb_wr_empty", 64'(exp_wr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
